dma_block_copy_ctrl: RTL and testbench
======================================

# dma_block_copy_ctrl

Memory-to-memory DMA sequencer for the 64×32 single-port RAM. It takes a source address, a destination address and a word count from the CPU configuration port. It then acquires the shared RAM bus through a hold/acknowledge handshake and moves the block one word at a time, as a read cycle followed by a write cycle. It sits between the CPU and the RAM; the top level uses `bus_own` to mux the RAM control, address and data lines between CPU and DMA.

## Interface
- AW, 6, RAM address width (RAM depth 2^AW)
- DW, 32, RAM data width
- clk  in  1  rising-edge clock shared with the RAM
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  config write strobe
- cfg_sel  in  2  0=src, 1=dst, 2=count, 3=ignored
- cfg_wdata  in  AW+1  config value; src/dst use the low AW bits, count uses all AW+1 bits (0..64)
- start  in  1  one-cycle start pulse
- abort  in  1  one-cycle abort pulse
- hold_ack  in  1  CPU grants the RAM bus
- ram_rdata  in  DW  RAM data bus as seen by the DMA
- hold_req  out  1  bus request to the CPU
- bus_own  out  1  DMA drives the RAM control and address lines
- ram_ctrl  out  1  0=RAM read (RAM drives data), 1=RAM write on the clk edge
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  write data
- ram_wdata_oe  out  1  top level drives ram_wdata onto the RAM data bus
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a transfer ends normally
- aborted  out  1  sticky abort flag; cleared by start or rst
- remaining  out  AW+1  words still to move

## Operation
- States: IDLE, REQ, RD, WR, DONE. State, src_ptr, dst_ptr, remaining and the data buffer are registers.
- All outputs are decoded from the current state only (Moore), so they are stable for the whole state cycle.
- Reset: state=IDLE; src, dst, remaining and buffer = 0; aborted=0.
  - Reset values of the outputs: hold_req=0, bus_own=0, ram_ctrl=0, ram_addr=0, ram_wdata=0, ram_wdata_oe=0, busy=0, done=0.
- Config: cfg_we is accepted only in IDLE and ignored otherwise. The count register loads remaining directly.
- IDLE: on start with remaining≠0, clear aborted and go to REQ. On start with remaining=0, go to DONE without touching the bus.
- REQ: hold_req=1. On hold_ack=1, go to RD.
- RD: hold_req=1, bus_own=1, ram_ctrl=0, ram_addr=src_ptr. At the clock edge: buffer←ram_rdata, src_ptr+1, go to WR.
- WR: hold_req=1, bus_own=1, ram_ctrl=1, ram_addr=dst_ptr, ram_wdata=buffer, ram_wdata_oe=1. At the clock edge: dst_ptr+1, remaining−1.
  - If the new remaining is 0, go to DONE.
  - Otherwise, if hold_ack=1 go to RD; if hold_ack=0 go to REQ.
- DONE: done=1, all bus outputs inactive. Go to IDLE.
- Pointers increment modulo 2^AW, so address 63 wraps to 0. Overlapping source and destination ranges are copied in ascending order with no overlap correction.
- If hold_ack drops during RD: the read still completes, then WR completes. Re-arbitration happens only at a word boundary.
- Abort in REQ, RD or WR: next state is IDLE and aborted=1, with no done pulse.
  - An abort during WR still lets that write commit, because ram_ctrl is already high on that edge.
  - The pointers and remaining keep their values at the abort.
- Abort together with start while in IDLE: abort wins, state stays IDLE, aborted=1.
- rst takes priority over everything, including mid-transfer: all registers and outputs return to their reset values on the next edge.

## Timing
- start sampled at edge N: busy=1 from cycle N+1 (REQ).
- With hold_ack already high: RD occupies cycle N+2 and WR occupies N+3.
- Steady state is 2 cycles per word.
- Total for K words with immediate grant: DONE in cycle N+2K+2, IDLE in N+2K+3.
- The RAM read is combinational and is sampled at the end of the RD cycle. The RAM write commits on the edge that ends the WR cycle.
- bus_own and hold_req never deassert between the words of one uninterrupted burst.

## Test plan
- RAM init M[i]=i; src=4, dst=40, count=3, start, hold_ack tied to 1 -> M[40..42]=4,5,6; done pulses in cycle N+8; remaining=0.
- src=62, dst=10, count=4 -> M[10..13]=62,63,0,1 (source wraps from 63 to 0).
- count=0, start -> done pulses in cycle N+1; ram_ctrl stays 0 and hold_req stays 0 throughout.
- hold_ack held low for 5 cycles after start, then dropped for 3 cycles after the first WR (count=2) -> state returns to REQ between the words; both words are copied correctly; hold_req stays high throughout.
- abort pulsed during the second WR of a count=5 transfer -> 2 words are written; aborted=1; remaining=3; no done pulse; a cfg write is accepted on the next cycle.
- rst asserted during RD -> next cycle all outputs are at their reset values and the destination word is unchanged.

Source files
------------

// File: rtl/dma_block_copy_ctrl.sv
// Memory-to-memory block copy sequencer for a shared single-port RAM.
// Acquires the bus with hold_req/hold_ack and moves one word per RD/WR pair.
module dma_block_copy_ctrl #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [AW:0]   cfg_wdata,
  input  logic          start,
  input  logic          abort,
  input  logic          hold_ack,
  input  logic [DW-1:0] ram_rdata,
  output logic          hold_req,
  output logic          bus_own,
  output logic          ram_ctrl,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wdata_oe,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW:0]   remaining
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [DW-1:0] buffer;
  logic [AW:0]   rem_dec;

  assign rem_dec = remaining - {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Re-arbitration only happens at a word boundary (end of WR).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && !abort)
          state_nx = (remaining != '0) ? REQ : DONE;
      end
      REQ: begin
        if (abort)         state_nx = IDLE;
        else if (hold_ack) state_nx = RD;
      end
      RD: begin
        state_nx = abort ? IDLE : WR;
      end
      WR: begin
        if (abort)                state_nx = IDLE;
        else if (rem_dec == '0)   state_nx = DONE;
        else if (hold_ack)        state_nx = RD;
        else                      state_nx = REQ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // An aborted RD/WR still finishes its datapath update.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      buffer    <= '0;
      aborted   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            unique case (cfg_sel)
              2'd0:    src_ptr   <= cfg_wdata[AW-1:0];
              2'd1:    dst_ptr   <= cfg_wdata[AW-1:0];
              2'd2:    remaining <= cfg_wdata;
              default: ;
            endcase
          end
          if (start) aborted <= abort;
        end
        REQ: begin
          if (abort) aborted <= 1'b1;
        end
        RD: begin
          buffer  <= ram_rdata;
          src_ptr <= src_ptr + 1'b1;
          if (abort) aborted <= 1'b1;
        end
        WR: begin
          dst_ptr   <= dst_ptr + 1'b1;
          remaining <= rem_dec;
          if (abort) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hold_req     = 1'b0;
    bus_own      = 1'b0;
    ram_ctrl     = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_wdata_oe = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;
    unique case (state)
      REQ: hold_req = 1'b1;
      RD: begin
        hold_req = 1'b1;
        bus_own  = 1'b1;
        ram_addr = src_ptr;
      end
      WR: begin
        hold_req     = 1'b1;
        bus_own      = 1'b1;
        ram_ctrl     = 1'b1;
        ram_addr     = dst_ptr;
        ram_wdata    = buffer;
        ram_wdata_oe = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_block_copy_ctrl.sv
// Bench for dma_block_copy_ctrl: RAM model, write scoreboard,
// table of transfers plus hold-drop, abort and reset sequences.
module tb_dma_block_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [6:0]  cfg_wdata;
  logic        start;
  logic        abort;
  logic        hold_ack;
  logic [31:0] ram_rdata;
  logic        hold_req;
  logic        bus_own;
  logic        ram_ctrl;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wdata_oe;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [6:0]  remaining;

  dma_block_copy_ctrl #(.AW(6), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .start(start), .abort(abort), .hold_ack(hold_ack),
    .ram_rdata(ram_rdata),
    .hold_req(hold_req), .bus_own(bus_own), .ram_ctrl(ram_ctrl),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wdata_oe(ram_wdata_oe),
    .busy(busy), .done(done), .aborted(aborted),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int src;
    int dst;
    int cnt;
    int done_rel;
  } vec_t;
  vec_t tbl[5];

  int n_cmp = 0;
  int n_bad = 0;
  int rel;
  int done_at;
  int ndone = 0;
  int nwr;
  bit ctrl_seen;
  bit hreq_seen;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observe the current cycle, then advance one clock.
  task automatic step();
    logic        wr;
    logic [5:0]  wa;
    logic [31:0] wd;
    exp_t        e;
    wr = bus_own && ram_ctrl && ram_wdata_oe;
    wa = ram_addr;
    wd = ram_wdata;
    if (wr) begin
      nwr++;
      if (sbq.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", wa, e.addr);
        check("wr_data", wd, e.data);
        ref_mem[e.addr] = e.data;
      end
    end
    if (done) begin
      done_at = rel;
      ndone++;
    end
    if (ram_ctrl) ctrl_seen = 1'b1;
    if (hold_req) hreq_seen = 1'b1;
    @(posedge clk);
    if (wr) mem[wa] = wd;
    rel++;
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input int val);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = 7'(val);
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic launch(input int src, input int dst, input int cnt);
    logic [31:0] tmp [0:63];
    exp_t e;
    cfg(2'd0, src);
    cfg(2'd1, dst);
    cfg(2'd2, cnt);
    for (int i = 0; i < 64; i++) tmp[i] = ref_mem[i];
    for (int i = 0; i < cnt; i++) begin
      e.addr = (dst + i) % 64;
      e.data = tmp[(src + i) % 64];
      tmp[e.addr] = e.data;
      sbq.push_back(e);
    end
    done_at   = -1;
    ctrl_seen = 1'b0;
    hreq_seen = 1'b0;
    nwr       = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    rel = 1;
  endtask

  task automatic run_to_done(input int budget);
    while (done_at < 0 && rel < budget) step();
    if (done_at < 0) check("timeout_done", rel, budget + 1);
  endtask

  initial begin
    int   gap;
    bit   hold_bad;
    int   nd0;
    logic [31:0] saved;

    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    tbl[0] = '{src: 4,  dst: 40, cnt: 3,  done_rel: 8};
    tbl[1] = '{src: 62, dst: 10, cnt: 4,  done_rel: 10};
    tbl[2] = '{src: 0,  dst: 0,  cnt: 0,  done_rel: 1};
    tbl[3] = '{src: 20, dst: 22, cnt: 5,  done_rel: 12};
    tbl[4] = '{src: 0,  dst: 63, cnt: 64, done_rel: 130};

    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0; hold_ack = 1'b0;
    rel = 0; done_at = -1; nwr = 0;
    repeat (2) step();
    check("rst_hold_req", hold_req, 0);
    check("rst_bus_own", bus_own, 0);
    check("rst_ram_ctrl", ram_ctrl, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wdata_oe", ram_wdata_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_remaining", remaining, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      hold_ack = 1'b1;
      launch(tbl[i].src, tbl[i].dst, tbl[i].cnt);
      check("busy_after_start", busy, 1);
      run_to_done(300);
      check("done_cycle", done_at, tbl[i].done_rel);
      check("remaining_end", remaining, 0);
      check("write_count", nwr, tbl[i].cnt);
      check("busy_end", busy, 0);
      if (tbl[i].cnt == 0) begin
        check("zero_ram_ctrl", ctrl_seen, 0);
        check("zero_hold_req", hreq_seen, 0);
      end
      if (i == 0) begin
        check("m40", mem[40], 4);
        check("m41", mem[41], 5);
        check("m42", mem[42], 6);
      end
      if (i == 1) begin
        check("m10", mem[10], 62);
        check("m11", mem[11], 63);
        check("m12", mem[12], 0);
        check("m13", mem[13], 1);
      end
      step();
    end

    // Grant withheld, then dropped across the word boundary.
    hold_ack = 1'b0;
    hold_bad = 1'b0;
    launch(30, 50, 2);
    repeat (5) begin
      if (!hold_req || bus_own) hold_bad = 1'b1;
      step();
    end
    hold_ack = 1'b1;
    for (int k = 0; k < 10 && !ram_ctrl; k++) step();
    check("hold_wr_reached", ram_ctrl, 1);
    hold_ack = 1'b0;
    step();
    gap = 0;
    repeat (3) begin
      if (hold_req && !bus_own) gap++;
      if (!hold_req) hold_bad = 1'b1;
      step();
    end
    hold_ack = 1'b1;
    run_to_done(100);
    check("hold_req_gap", gap, 3);
    check("hold_req_steady", hold_bad, 0);
    check("hold_writes", nwr, 2);
    step();

    // Abort during the second write.
    launch(0, 20, 5);
    for (int k = 0; k < 20 && !(ram_ctrl && nwr == 1); k++) step();
    check("abort_wr_reached", ram_ctrl, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_flag", aborted, 1);
    check("abort_remaining", remaining, 3);
    check("abort_writes", nwr, 2);
    sbq.delete();
    nd0 = ndone;
    launch(7, 60, 1);
    check("abort_cleared", aborted, 0);
    run_to_done(50);
    check("post_abort_done", done_at, 4);
    check("abort_no_done", ndone, nd0 + 1);
    step();

    // Abort wins over start in IDLE.
    cfg(2'd2, 2);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_flag", aborted, 1);

    // Reset in the middle of a read.
    saved = mem[45];
    launch(5, 45, 2);
    for (int k = 0; k < 10 && !(bus_own && !ram_ctrl); k++) step();
    check("rst_rd_reached", bus_own, 1);
    rst = 1'b1;
    step();
    check("mid_rst_hold_req", hold_req, 0);
    check("mid_rst_bus_own", bus_own, 0);
    check("mid_rst_ram_ctrl", ram_ctrl, 0);
    check("mid_rst_ram_addr", ram_addr, 0);
    check("mid_rst_wdata", ram_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_remaining", remaining, 0);
    check("mid_rst_aborted", aborted, 0);
    rst = 1'b0;
    step();
    check("mid_rst_dst_kept", mem[45], saved);
    sbq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
